fetch_unit: RTL and testbench

Instruction-fetch initiator that drives the synchronous-read instruction memory and delivers instructions to decode. It owns the PC, issues one word address per cycle and tracks the single-cycle memory read latency. Returned words go into a small FIFO with valid/ready to decode. It also handles control-flow redirects by flushing wrong-path data.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch initiator for a synchronous-read instruction
// memory. Owns the PC, issues one word address per cycle, tracks the
// single-cycle read latency and buffers returned words in a small FIFO that
// feeds decode over valid/ready. Redirects flush wrong-path data.
// Optional build macro FETCH_PERF_CNT_EN adds fetched/stall counters.
module fetch_unit #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr_out,
  input  logic [31:0] imem_data_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        inst_valid_out,
  input  logic        inst_ready_in,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetched_count_out,
  output logic [31:0] stall_count_out
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic [31:0]   pc_q;
  logic [31:0]   req_pc_q;
  logic          req_q;
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [31:0]   target;
  logic          redirect;
  logic          pop;
  logic          push;
  logic          credit;
  logic [OW-1:0] occupancy;

  assign target   = {redirect_pc_in[31:2], 2'b00};
  // Gated by rst_n so the address stays at RESET_PC throughout reset.
  assign redirect = redirect_valid_in & rst_n;

  assign inst_valid_out = (count != '0);
  assign inst_out       = fifo_inst[rd_ptr];
  assign inst_pc_out    = fifo_pc[rd_ptr];
  assign imem_addr_out  = redirect ? target : pc_q;

  // Handshake, response acceptance and issue credit.
  // Occupancy counts the in-flight word so issuing never overruns the FIFO.
  always_comb begin
    pop       = inst_valid_out & inst_ready_in;
    push      = req_q & ~redirect;
    occupancy = OW'(count) + OW'(req_q) - OW'(pop);
    credit    = (occupancy < OW'(FIFO_DEPTH));
  end

  // PC, in-flight request tracking and FIFO pointers; redirect has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      pc_q     <= target + 32'd4;
      req_q    <= 1'b1;
      req_pc_q <= target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (credit) begin
        req_q    <= 1'b1;
        req_pc_q <= pc_q;
        pc_q     <= pc_q + 32'd4;
      end else begin
        req_q    <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Instruction buffer storage; cleared on reset so the head is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (push) begin
      fifo_inst[wr_ptr] <= imem_data_in;
      fifo_pc[wr_ptr]   <= req_pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Delivered-instruction and decode-stall counters; redirects leave them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_count_out <= '0;
      stall_count_out   <= '0;
    end else begin
      if (pop) fetched_count_out <= fetched_count_out + 32'd1;
      if (inst_valid_out && !inst_ready_in) stall_count_out <= stall_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Expected PCs are queued
// when reset release or a redirect is driven and popped on each accepted
// instruction. A second instance checks PC wrap from RESET_PC=FFFF_FFF8.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic [31:0] b_addr;
  logic [31:0] b_data = '0;
  logic        b_valid;
  logic [31:0] b_inst;
  logic [31:0] b_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_count;
  logic [31:0] stall_count;
  logic [31:0] b_fetched_count;
  logic [31:0] b_stall_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  always #5 clk = ~clk;

  fetch_unit #(.FIFO_DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr_out    (imem_addr),
    .imem_data_in     (imem_data),
    .redirect_valid_in(redirect_valid),
    .redirect_pc_in   (redirect_pc),
    .inst_valid_out   (inst_valid),
    .inst_ready_in    (inst_ready),
    .inst_out         (inst),
    .inst_pc_out      (inst_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_count_out(fetched_count),
    .stall_count_out  (stall_count)
`endif
  );

  fetch_unit #(.FIFO_DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr_out    (b_addr),
    .imem_data_in     (b_data),
    .redirect_valid_in(1'b0),
    .redirect_pc_in   (32'h0),
    .inst_valid_out   (b_valid),
    .inst_ready_in    (1'b1),
    .inst_out         (b_inst),
    .inst_pc_out      (b_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_count_out(b_fetched_count),
    .stall_count_out  (b_stall_count)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous-read instruction memories.
  always @(posedge clk) begin
    imem_data <= mem_word(imem_addr);
    b_data    <= mem_word(b_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [31:0] start);
    for (int unsigned i = 0; i < 64; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every accepted instruction, then apply any redirect.
  always @(negedge clk) begin
    if (rst_n) begin
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          sb_exp = exp_q.pop_front();
          check("sb_pc", inst_pc, sb_exp);
          check("sb_inst", inst, mem_word(sb_exp));
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        fill({redirect_pc[31:2], 2'b00});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] wexp;
    rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_addr_wrap", b_addr, 32'hFFFF_FFF8);
    exp_q.delete();
    fill(32'h0);

    // Reset release and streaming latency.
    tick(); rst_n = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    check("c0_valid", {31'b0, inst_valid}, 32'd0);
    check("c0_addr", imem_addr, 32'h0);
    tick(); @(negedge clk);
    check("c1_valid", {31'b0, inst_valid}, 32'd0);
    check("c1_addr", imem_addr, 32'h4);
    tick(); @(negedge clk);
    check("c2_valid", {31'b0, inst_valid}, 32'd1);
    check("c2_pc", inst_pc, 32'h0);
    check("c2_inst", inst, 32'h1000_0000);
    check("wrap_valid", {31'b0, b_valid}, 32'd1);
    check("wrap_pc0", b_pc, 32'hFFFF_FFF8);
    for (int i = 1; i <= 3; i++) begin
      tick(); @(negedge clk);
      wexp = 32'hFFFF_FFF8 + 32'(4 * i);
      check("stream_valid", {31'b0, inst_valid}, 32'd1);
      check("wrap_pc", b_pc, wexp);
      check("wrap_inst", b_inst, mem_word(wexp));
    end

    // Backpressure: head must hold for six cycles.
    tick(); inst_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, inst_valid}, 32'd1);
      check("hold_pc", inst_pc, exp_q[0]);
      check("hold_inst", inst, mem_word(exp_q[0]));
      tick();
    end
    inst_ready = 1'b1;
    repeat (6) tick();

    // Redirect mid-stream with ready high.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    check("redir_addr", imem_addr, 32'h40);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_r1_valid", {31'b0, inst_valid}, 32'd0);
    tick(); @(negedge clk);
    check("redir_r2_valid", {31'b0, inst_valid}, 32'd1);
    check("redir_r2_pc", inst_pc, 32'h40);
    tick(); @(negedge clk);
    check("redir_r3_pc", inst_pc, 32'h44);

    // Redirect to an unaligned target with a full FIFO and ready low.
    tick(); inst_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h23;
    @(negedge clk);
    check("full_redir_addr", imem_addr, 32'h20);
    check("full_redir_valid", {31'b0, inst_valid}, 32'd1);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    check("full_r1_valid", {31'b0, inst_valid}, 32'd0);
    tick(); @(negedge clk);
    check("full_r2_valid", {31'b0, inst_valid}, 32'd1);
    check("full_r2_pc", inst_pc, 32'h20);
    check("full_r2_inst", inst, mem_word(32'h20));
    tick(); @(negedge clk);
    check("full_r3_pc", inst_pc, 32'h20);
    tick(); inst_ready = 1'b1;
    repeat (4) tick();

    // Asynchronous reset with a non-empty FIFO.
    inst_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, inst_valid}, 32'd0);
    check("arst_pc", inst_pc, 32'h0);
    check("arst_inst", inst, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    exp_q.delete();
    fill(32'h0);
    tick(); tick();
    rst_n = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    check("rs_c0_valid", {31'b0, inst_valid}, 32'd0);
    tick(); @(negedge clk);
    check("rs_c1_valid", {31'b0, inst_valid}, 32'd0);
    tick(); @(negedge clk);
    check("rs_c2_valid", {31'b0, inst_valid}, 32'd1);
    check("rs_c2_pc", inst_pc, 32'h0);
    // Pops in cycles 2..11, stalls in cycles 12..14.
    repeat (9) tick();
    tick(); inst_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("stall_valid", {31'b0, inst_valid}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", fetched_count, 32'd10);
    check("perf_stall", stall_count, 32'd3);
`endif
    tick(); inst_ready = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
